// File: rtl/conv_back_mac_pkg.sv
// Shared types, default parameters and round/saturate helpers for the
// backward-convolution multi-lane MAC.
package conv_back_mac_pkg;

    localparam int DW_DEF      = 16;
    localparam int LANES_DEF   = 4;
    localparam int ACC_LEN_DEF = 16;
    localparam int FRAC_DEF    = 0;

    // Accumulators are widened to this before rounding; covers ACC_W up to 64.
    localparam int WIDE_W = 64;
    typedef logic signed [WIDE_W-1:0] wide_t;

    // Tag travelling alongside the stage-1 product registers.
    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } beat_tag_t;

    function automatic int lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction

    // Arithmetic right shift with round-half-up.
    function automatic wide_t round_shift(input wide_t v, input int frac);
        wide_t r;
        r = v;
        if (frac > 0) begin
            r = v + (wide_t'(1) <<< (frac - 1));
        end
        return r >>> frac;
    endfunction

    function automatic wide_t sat_hi(input int dw);
        return (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t sat_lo(input int dw);
        return -(wide_t'(1) <<< (dw - 1));
    endfunction

endpackage

// File: rtl/conv_back_mac_if.sv
// Beat/result handshake bundle between a producer/consumer and conv_back_mac.
interface conv_back_mac_if
    import conv_back_mac_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int LANES = LANES_DEF
);
    logic                  en_reg;
    logic                  in_ready;
    logic [LANES*DW-1:0]   in;
    logic [DW-1:0]         weight;
    logic                  clr;
    logic [LANES*DW-1:0]   result;
    logic                  conv_sig;
    logic                  res_ready;
    logic [LANES-1:0]      ovf;
    logic                  busy;

    modport master (
        output en_reg, in, weight, clr, res_ready,
        input  in_ready, result, conv_sig, ovf, busy
    );

    modport slave (
        input  en_reg, in, weight, clr, res_ready,
        output in_ready, result, conv_sig, ovf, busy
    );
endinterface

// File: rtl/conv_back_mac_lane.sv
// One lane: product register, window accumulator and the rounded/saturated
// output register. All sequencing decisions come from the top.
module conv_back_lane
    import conv_back_mac_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int ACC_LEN = ACC_LEN_DEF,
    parameter int FRAC    = FRAC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mul_en_i,
    input  logic                 acc_en_i,
    input  logic                 first_i,
    input  logic                 clr_i,
    input  logic                 wr_en_i,
    input  logic signed [DW-1:0] in_i,
    input  logic signed [DW-1:0] weight_i,
    output logic        [DW-1:0] result_o,
    output logic                 ovf_o
);

    localparam int ACC_W = 2 * DW + $clog2(ACC_LEN);

    logic signed [2*DW-1:0]  prod_q, prod_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, prod_ext;
    logic        [DW-1:0]    res_q, res_d;
    logic                    ovf_q, ovf_d;
    wide_t                   acc_wide, rounded;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        prod_d   = in_i * weight_i;
        prod_ext = {{(ACC_W-2*DW){prod_q[2*DW-1]}}, prod_q};
        acc_d    = first_i ? prod_ext : acc_q + prod_ext;
        acc_wide = {{(WIDE_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
        rounded  = round_shift(acc_wide, FRAC);
        res_d    = rounded[DW-1:0];
        ovf_d    = 1'b0;
        if (rounded > sat_hi(DW)) begin
            res_d = {1'b0, {(DW-1){1'b1}}};
            ovf_d = 1'b1;
        end else if (rounded < sat_lo(DW)) begin
            res_d = {1'b1, {(DW-1){1'b0}}};
            ovf_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            acc_q  <= '0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (mul_en_i) begin
                prod_q <= prod_d;
            end
            if (clr_i) begin
                acc_q <= '0;
            end else if (acc_en_i) begin
                acc_q <= acc_d;
            end
            if (wr_en_i) begin
                res_q <= res_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign result_o = res_q;
    assign ovf_o    = ovf_q;

endmodule

// File: rtl/conv_back_mac.sv
// Multi-lane streaming MAC for the backward-conv path: beat counter,
// pipeline valid/tag tracking and the result handshake; lanes do the math.
module conv_back_mac
    import conv_back_mac_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int LANES   = LANES_DEF,
    parameter int ACC_LEN = ACC_LEN_DEF,
    parameter int FRAC    = FRAC_DEF
) (
    input logic             clk,
    input logic             rst,
    conv_back_mac_if.slave  bus
);

    localparam int             CNT_W    = $clog2(ACC_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    beat_tag_t        s1_q, s1_d;
    logic             s2_vld_q, s2_vld_d;
    logic             s2_last_q, s2_last_d;
    logic             conv_sig_q, conv_sig_d;
    logic             stall, accept, wr_en;

    // A held result that nobody takes freezes the whole pipeline.
    assign stall  = conv_sig_q & ~bus.res_ready;
    assign accept = bus.en_reg & ~stall & ~bus.clr;
    assign wr_en  = s2_vld_q & s2_last_q & ~stall & ~bus.clr;

    always_comb begin
        cnt_d      = cnt_q;
        s1_d       = s1_q;
        s2_vld_d   = s2_vld_q;
        s2_last_d  = s2_last_q;
        conv_sig_d = conv_sig_q;
        if (bus.clr) begin
            cnt_d     = '0;
            s1_d      = '0;
            s2_vld_d  = 1'b0;
            s2_last_d = 1'b0;
        end else if (!stall) begin
            s1_d.vld   = accept;
            s1_d.first = (cnt_q == '0);
            s1_d.last  = (cnt_q == CNT_LAST);
            if (accept) begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            end
            s2_vld_d  = s1_q.vld;
            s2_last_d = s1_q.vld & s1_q.last;
        end
        // A fresh write keeps conv_sig high even while the old result is taken.
        if (wr_en) begin
            conv_sig_d = 1'b1;
        end else if (conv_sig_q && bus.res_ready) begin
            conv_sig_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            s1_q       <= '0;
            s2_vld_q   <= 1'b0;
            s2_last_q  <= 1'b0;
            conv_sig_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            s1_q       <= s1_d;
            s2_vld_q   <= s2_vld_d;
            s2_last_q  <= s2_last_d;
            conv_sig_q <= conv_sig_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        conv_back_lane #(
            .DW      (DW),
            .ACC_LEN (ACC_LEN),
            .FRAC    (FRAC)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .mul_en_i (accept),
            .acc_en_i (s1_q.vld & ~stall),
            .first_i  (s1_q.first),
            .clr_i    (bus.clr),
            .wr_en_i  (wr_en),
            .in_i     (bus.in[lane_lsb(k, DW) +: DW]),
            .weight_i (bus.weight),
            .result_o (bus.result[lane_lsb(k, DW) +: DW]),
            .ovf_o    (bus.ovf[k])
        );
    end

    assign bus.in_ready = ~stall;
    assign bus.conv_sig = conv_sig_q;
    assign bus.busy     = (cnt_q != '0) | s1_q.vld | s2_vld_q;

endmodule

// File: tb/tb_conv_back_mac.sv
// Self-checking bench for conv_back_mac: directed windows, a vector table,
// a FRAC=4 instance and randomized traffic against a window-sum model.
module tb_conv_back_mac;

    localparam int DW      = 16;
    localparam int LANES   = 4;
    localparam int ACC_LEN = 16;
    localparam int VW      = LANES * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_back_mac_if #(.DW(DW), .LANES(LANES)) bus   ();
    conv_back_mac_if #(.DW(DW), .LANES(LANES)) bus_f ();

    conv_back_mac #(.DW(DW), .LANES(LANES), .ACC_LEN(ACC_LEN), .FRAC(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    conv_back_mac #(.DW(DW), .LANES(LANES), .ACC_LEN(ACC_LEN), .FRAC(4)) dut_f (
        .clk (clk),
        .rst (rst),
        .bus (bus_f)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: exact window sum, scaled with round-half-up, then clipped.
    function automatic logic [DW:0] model_lane(input longint sum, input int frac);
        longint d, r, q, hi, lo;
        d  = longint'(1) << frac;
        r  = sum + ((frac > 0) ? d / 2 : 0);
        q  = r / d;
        if ((r % d != 0) && (r < 0)) q = q - 1;
        hi = (longint'(1) << (DW - 1)) - 1;
        lo = -(longint'(1) << (DW - 1));
        if (q > hi) return {1'b1, DW'(hi)};
        if (q < lo) return {1'b1, DW'(lo)};
        return {1'b0, DW'(q)};
    endfunction

    typedef struct packed {
        logic [VW-1:0]    res;
        logic [LANES-1:0] ovf;
    } exp_t;

    longint      m_sum [LANES];
    int          m_cnt = 0;
    exp_t        exp_q [$];
    exp_t        m_e;
    logic [DW:0] lr;
    int          cyc = 0;
    int          hs_cyc [$];
    int          wait_cycles = 0;

    // Scoreboard: looks at what the coming edge will do on the FRAC=0 instance.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            for (int k = 0; k < LANES; k++) m_sum[k] = 0;
            m_cnt = 0;
            exp_q.delete();
        end else begin
            if (bus.conv_sig && bus.res_ready) begin
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_result", 64'(bus.conv_sig), 64'd0);
                end else begin
                    m_e = exp_q.pop_front();
                    check("sb_result", bus.result, m_e.res);
                    check("sb_ovf", 64'(bus.ovf), 64'(m_e.ovf));
                end
            end
            if (bus.clr) begin
                for (int k = 0; k < LANES; k++) m_sum[k] = 0;
                m_cnt = 0;
            end else if (bus.en_reg && bus.in_ready) begin
                for (int k = 0; k < LANES; k++)
                    m_sum[k] += longint'($signed(bus.in[k*DW +: DW])) * longint'($signed(bus.weight));
                m_cnt++;
                if (m_cnt == ACC_LEN) begin
                    for (int k = 0; k < LANES; k++) begin
                        lr = model_lane(m_sum[k], 0);
                        m_e.res[k*DW +: DW] = lr[DW-1:0];
                        m_e.ovf[k] = lr[DW];
                        m_sum[k] = 0;
                    end
                    exp_q.push_back(m_e);
                    m_cnt = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [VW-1:0] v, input logic [DW-1:0] w);
        logic acc;
        bus.en_reg = 1'b1;
        bus.in     = v;
        bus.weight = w;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            acc = bus.in_ready && !bus.clr;
            step();
            if (acc) return;
            wait_cycles++;
        end
        check("beat_accept_timeout", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic wait_conv(input string tag, input int budget);
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (bus.conv_sig) return;
        end
        check({tag, "_timeout"}, 64'(bus.conv_sig), 64'd1);
    endtask

    function automatic logic [VW-1:0] lane0(input int val);
        logic [VW-1:0] v;
        v = '0;
        v[DW-1:0] = DW'(val);
        return v;
    endfunction

    task automatic send_window_t1();
        for (int j = 0; j < ACC_LEN; j++) send_beat(lane0(j + 1), DW'(23 - j));
    endtask

    typedef struct packed {
        logic [VW-1:0]    in_v;
        logic [DW-1:0]    w;
        logic [VW-1:0]    exp_res;
        logic [LANES-1:0] exp_ovf;
    } vec_t;

    vec_t tv [4];
    logic [VW-1:0] v_f;
    logic [VW-1:0] rv;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // lanes packed {lane3, lane2, lane1, lane0}; constant over a window
        tv[0] = '{in_v: {4{16'h7FFF}}, w: 16'h7FFF,
                  exp_res: {4{16'h7FFF}}, exp_ovf: 4'b1111};
        tv[1] = '{in_v: {16'h0000, 16'h7FFF, 16'h8000, 16'h8000}, w: 16'h7FFF,
                  exp_res: {16'h0000, 16'h7FFF, 16'h8000, 16'h8000}, exp_ovf: 4'b0111};
        tv[2] = '{in_v: {16'd2048, 16'd2047, 16'hFFFD, 16'd1}, w: 16'd1,
                  exp_res: {16'h7FFF, 16'h7FF0, 16'hFFD0, 16'd16}, exp_ovf: 4'b1000};
        tv[3] = '{in_v: {16'd5, 16'd0, 16'hFF9C, 16'd100}, w: 16'hFF9C,
                  exp_res: {16'hE0C0, 16'h0000, 16'h7FFF, 16'h8000}, exp_ovf: 4'b0011};

        bus.en_reg = 1'b0; bus.in = '0; bus.weight = '0; bus.clr = 1'b0; bus.res_ready = 1'b1;
        bus_f.en_reg = 1'b0; bus_f.in = '0; bus_f.weight = '0; bus_f.clr = 1'b0; bus_f.res_ready = 1'b1;

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        check("rst_result", bus.result, 64'd0);
        check("rst_conv_sig", 64'(bus.conv_sig), 64'd0);
        check("rst_ovf", 64'(bus.ovf), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;
        step();
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Single window: latency and one-cycle pulse
        send_window_t1();
        bus.en_reg = 1'b0;
        check("t1_edge0_conv_sig", 64'(bus.conv_sig), 64'd0);
        step();
        check("t1_edge1_conv_sig", 64'(bus.conv_sig), 64'd0);
        step();
        check("t1_edge2_conv_sig", 64'(bus.conv_sig), 64'd1);
        check("t1_result", bus.result, 64'd1768);
        check("t1_ovf", 64'(bus.ovf), 64'd0);
        step();
        check("t1_pulse_end", 64'(bus.conv_sig), 64'd0);
        check("t1_busy_idle", 64'(bus.busy), 64'd0);

        // Back-to-back windows, operands swapped
        wait_cycles = 0;
        hs_cyc.delete();
        for (int n = 0; n < 2; n++)
            for (int j = 0; j < ACC_LEN; j++) send_beat(lane0(23 - j), DW'(j + 1));
        bus.en_reg = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (hs_cyc.size() >= 2) break;
            step();
        end
        check("t2_results_seen", 64'(hs_cyc.size()), 64'd2);
        check("t2_in_ready_never_low", 64'(wait_cycles), 64'd0);
        if (hs_cyc.size() >= 2) check("t2_spacing", 64'(hs_cyc[1] - hs_cyc[0]), 64'(ACC_LEN));

        // Output stall for 10 cycles while beats keep coming
        bus.res_ready = 1'b0;
        wait_cycles = 0;
        fork
            begin
                send_window_t1();
                send_window_t1();
                bus.en_reg = 1'b0;
            end
            begin
                wait_conv("t3_first", 100);
                for (int t = 0; t < 10; t++) begin
                    if (t > 0) @(negedge clk);
                    check($sformatf("t3_stall_in_ready_%0d", t), 64'(bus.in_ready), 64'd0);
                    check($sformatf("t3_stall_result_%0d", t), bus.result, 64'd1768);
                end
                @(posedge clk);
                #1;
                bus.res_ready = 1'b1;
            end
        join
        check("t3_stalled_cycles", 64'(wait_cycles >= 10), 64'd1);
        wait_conv("t3_second", 10);
        check("t3_second_result", bus.result, 64'd1768);
        step();

        // Saturation / sign vector table
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < ACC_LEN; j++) send_beat(tv[i].in_v, tv[i].w);
            bus.en_reg = 1'b0;
            wait_conv($sformatf("tv%0d", i), 10);
            check($sformatf("tv%0d_result", i), bus.result, tv[i].exp_res);
            check($sformatf("tv%0d_ovf", i), 64'(bus.ovf), 64'(tv[i].exp_ovf));
            step();
        end

        // FRAC=4 rounding: lane sums 24, -24, 23, -8
        for (int j = 0; j < ACC_LEN; j++) begin
            v_f = '0;
            if (j < 8) begin
                v_f[0*DW +: DW] = 16'd3;
                v_f[1*DW +: DW] = 16'hFFFD;
            end
            if (j == 0) begin
                v_f[2*DW +: DW] = 16'd23;
                v_f[3*DW +: DW] = 16'hFFF8;
            end
            bus_f.en_reg = 1'b1;
            bus_f.in     = v_f;
            bus_f.weight = 16'd1;
            step();
        end
        bus_f.en_reg = 1'b0;
        bus_f.in     = '0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (bus_f.conv_sig) break;
        end
        check("frac_conv_sig", 64'(bus_f.conv_sig), 64'd1);
        check("frac_result", bus_f.result, {16'h0000, 16'h0001, 16'hFFFF, 16'h0002});
        check("frac_ovf", 64'(bus_f.ovf), 64'd0);
        step();

        // Abort after 7 beats, then a clean window
        for (int j = 0; j < 7; j++) send_beat(lane0(j + 1), DW'(23 - j));
        bus.en_reg = 1'b0;
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        check("t6_busy_after_clr", 64'(bus.busy), 64'd0);
        send_window_t1();
        bus.en_reg = 1'b0;
        wait_conv("t6_after_clr", 10);
        check("t6_after_clr_result", bus.result, 64'd1768);
        step();

        // Reset in the middle of a window
        for (int j = 0; j < 5; j++) send_beat(lane0(j + 1), DW'(23 - j));
        bus.in = lane0(6);
        rst = 1'b1;
        step();
        check("t6_rst_result", bus.result, 64'd0);
        check("t6_rst_conv_sig", 64'(bus.conv_sig), 64'd0);
        check("t6_rst_ovf", 64'(bus.ovf), 64'd0);
        check("t6_rst_busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;
        bus.en_reg = 1'b0;
        step();
        check("t6_rst_in_ready", 64'(bus.in_ready), 64'd1);
        send_window_t1();
        bus.en_reg = 1'b0;
        wait_conv("t6_after_rst", 10);
        check("t6_after_rst_result", bus.result, 64'd1768);
        step();

        // Randomized traffic with gaps, backpressure and occasional aborts
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < LANES; k++)
                rv[k*DW +: DW] = ($urandom_range(0, 3) == 0) ? DW'($urandom)
                                                             : DW'($urandom_range(0, 511) - 256);
            bus.in        = rv;
            bus.weight    = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 511) - 256);
            bus.en_reg    = ($urandom_range(0, 3) != 0);
            bus.res_ready = ($urandom_range(0, 9) < 7);
            bus.clr       = (m_cnt >= 3) && ($urandom_range(0, 59) == 0);
            step();
        end
        bus.en_reg    = 1'b0;
        bus.clr       = 1'b0;
        bus.res_ready = 1'b1;
        for (int t = 0; t < 60; t++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        check("rand_drain", 64'(exp_q.size()), 64'd0);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        step();
        check("rand_final_busy", 64'(bus.busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
